matmul_operand_loader: RTL

MATMUL_OPERAND_LOADER -- requirements
Module: matmul_operand_loader

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_hold_timer.sv | 43 ++++
 rtl/matmul_operand_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and loader state type for the 2x2 matmul operand loader.
package matmul_pkg;

  localparam int ELEM_W        = 8;
  localparam int ELEMS_PER_MAT = 4;
  localparam int BEATS_PER_OP  = 8;
  localparam int MAT_W         = ELEM_W * ELEMS_PER_MAT;
  localparam int LOADED_W      = 3;
  localparam int HOLD_W        = 4;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_ISSUE = 1'b1
  } loader_state_e;

endpackage

// File: rtl/matmul_hold_timer.sv
// Counts the cycles an issued operand pair is held; done marks the final hold cycle.
module matmul_hold_timer
  import matmul_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  assign done = (cnt_q == HOLD_LAST);

  // load marks the first hold cycle as 1; the counter parks at 0 once the hold ends.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = HOLD_W'(1);
    end else if (count) begin
      if (done) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matmul_operand_loader.sv
// Collects 8 streamed elements into packed 2x2 A/B operands and holds them HOLD_CYCLES.
// Optional feature macro: MATMUL_LOADER_ZERO_IDLE_EN (A/B read 0 while op_valid is low).
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [31:0]       A,
  output logic [31:0]       B,
  output logic              op_valid,
  output logic [2:0]        loaded
);

  localparam int                 NUM_SHADOW  = BEATS_PER_OP - 1;
  localparam logic [LOADED_W-1:0] LAST_BEAT  = LOADED_W'(BEATS_PER_OP - 1);

  loader_state_e              state_q;
  loader_state_e              state_d;
  logic [LOADED_W-1:0]        loaded_q;
  logic [LOADED_W-1:0]        loaded_d;
  logic [MAT_W-1:0]           a_q;
  logic [MAT_W-1:0]           a_d;
  logic [MAT_W-1:0]           b_q;
  logic [MAT_W-1:0]           b_d;
  logic [NUM_SHADOW*ELEM_W-1:0] shadow_flat;

  logic in_load;
  logic beat_accept;
  logic timer_load;
  logic timer_count;
  logic timer_done;

  assign in_load     = (state_q == ST_LOAD);
  assign beat_accept = in_valid && in_load && !flush;

  // Only the first seven beats are parked; the eighth goes straight into B22.
  for (genvar gi = 0; gi < NUM_SHADOW; gi++) begin : g_shadow
    logic [ELEM_W-1:0] sh_q;
    logic [ELEM_W-1:0] sh_d;

    always_comb begin
      sh_d = sh_q;
      if (in_load && flush) begin
        sh_d = '0;
      end else if (beat_accept && (loaded_q == LOADED_W'(gi))) begin
        sh_d = in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q <= '0;
      end else begin
        sh_q <= sh_d;
      end
    end

    assign shadow_flat[gi*ELEM_W +: ELEM_W] = sh_q;
  end

  matmul_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .count (timer_count),
    .done  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    a_d         = a_q;
    b_d         = b_q;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (flush) begin
          loaded_d = '0;
        end else if (beat_accept) begin
          if (loaded_q == LAST_BEAT) begin
            a_d        = shadow_flat[MAT_W-1:0];
            b_d        = {in_data, shadow_flat[NUM_SHADOW*ELEM_W-1:MAT_W]};
            loaded_d   = '0;
            state_d    = ST_ISSUE;
            timer_load = 1'b1;
          end else begin
            loaded_d = loaded_q + LOADED_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        // flush and in_data are deliberately ignored until the hold completes.
        timer_count = 1'b1;
        if (timer_done) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      loaded_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign in_ready = in_load;
  assign op_valid = (state_q == ST_ISSUE);
  assign loaded   = loaded_q;

`ifdef MATMUL_LOADER_ZERO_IDLE_EN
  assign A = op_valid ? a_q : '0;
  assign B = op_valid ? b_q : '0;
`else
  assign A = a_q;
  assign B = b_q;
`endif

endmodule
